// File: rtl/cei_mochila_pkg.sv
// rtl/cei_mochila_pkg.sv - TMR error monitor register map, bit positions and FSM states
package cei_mochila_pkg;

    localparam logic [31:0] TMR_STATUS_OFFSET    = 32'h00;
    localparam logic [31:0] TMR_CNT_OFFSET       = 32'h04;
    localparam logic [31:0] TMR_THRESHOLD_OFFSET = 32'h10;
    localparam logic [31:0] TMR_CTRL_OFFSET      = 32'h14;
    localparam logic [31:0] TMR_TIMESTAMP_OFFSET = 32'h18;

    localparam int unsigned TMR_STATUS_FATAL_BIT = 31;
    localparam int unsigned TMR_CTRL_IRQ_EN_BIT  = 0;
    localparam int unsigned TMR_CTRL_REC_EN_BIT  = 1;

    typedef enum logic [1:0] {
        TMR_IDLE  = 2'd0,
        TMR_REQ   = 2'd1,
        TMR_FATAL = 2'd2
    } tmr_mon_state_e;

endpackage

// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - register bus request/response types used by the CSR bridge
package reg_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/tmr_err_counter.sv
// rtl/tmr_err_counter.sv - saturating per-hart error counter, clear has priority but keeps a same-cycle event
module tmr_err_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear restarts from the concurrent event so it is not lost; otherwise saturate at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = inc_i ? CNT_W'(1) : '0;
        end else if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tmr_error_monitor.sv
// rtl/tmr_error_monitor.sv - TMR voter error monitor with CSRs, irq and recovery FSM; option CEI_TMR_ERR_TIMESTAMP_EN
module tmr_error_monitor
    import cei_mochila_pkg::*;
#(
    parameter int unsigned NHARTS     = 3,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned THRESH_RST = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              error_i,
    input  logic [NHARTS-1:0] error_id_i,
    input  logic              tmr_active_i,
    input  reg_pkg::reg_req_t reg_req_i,
    output reg_pkg::reg_rsp_t reg_rsp_o,
    output logic              recovery_req_o,
    output logic [NHARTS-1:0] recovery_hart_o,
    input  logic              recovery_ack_i,
    output logic              fatal_o,
    output logic              irq_o
);

    logic              evt;
    logic              multi_hart;
    logic              uncorr_evt;
    logic              single_evt;

    logic              wr;
    logic              wr_status;
    logic              wr_thresh;
    logic              wr_ctrl;
    logic [NHARTS-1:0] cnt_wr;
    logic [NHARTS-1:0] cnt_inc;
    logic [NHARTS-1:0] cnt_clr;
    logic [NHARTS-1:0] ack_clr;
    logic [CNT_W-1:0]  cnt [NHARTS];

    logic [NHARTS-1:0] status_hart_q, status_hart_d;
    logic              status_fatal_q, status_fatal_d;
    logic [CNT_W-1:0]  threshold_q, threshold_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              irq_q, irq_d;

    tmr_mon_state_e    state_q, state_d;
    logic              req_q, req_d;
    logic [NHARTS-1:0] hart_q, hart_d;
    logic              fatal_q, fatal_d;
    logic [NHARTS-1:0] sel_hart;

    logic [31:0]       rdata;
    logic              unused_wdata;

    // A zero id or more than one outvoted hart cannot be corrected by resyncing one hart
    assign evt        = error_i & tmr_active_i;
    assign multi_hart = |(error_id_i & (error_id_i - NHARTS'(1)));
    assign uncorr_evt = evt & ((error_id_i == '0) | multi_hart);
    assign single_evt = evt & ~uncorr_evt;

    assign wr        = reg_req_i.valid & reg_req_i.write;
    assign wr_status = wr & (reg_req_i.addr == TMR_STATUS_OFFSET);
    assign wr_thresh = wr & (reg_req_i.addr == TMR_THRESHOLD_OFFSET);
    assign wr_ctrl   = wr & (reg_req_i.addr == TMR_CTRL_OFFSET);
    assign unused_wdata = ^reg_req_i.wdata;

    // Per-hart counter write decode: any write to CNT[k] clears it
    always_comb begin
        cnt_wr = '0;
        for (int k = 0; k < int'(NHARTS); k++) begin
            cnt_wr[k] = wr & (reg_req_i.addr == TMR_CNT_OFFSET + 32'(4 * k));
        end
    end

    assign cnt_inc = single_evt ? error_id_i : '0;
    assign cnt_clr = cnt_wr | ack_clr;

    for (genvar g = 0; g < int'(NHARTS); g++) begin : g_cnt
        tmr_err_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (cnt_clr[g]),
            .inc_i  (cnt_inc[g]),
            .cnt_o  (cnt[g])
        );
    end

    // Sticky status with W1C; a same-cycle event re-sets the bit being cleared
    always_comb begin
        status_hart_d  = (status_hart_q & ~(wr_status ? reg_req_i.wdata[NHARTS-1:0] : '0))
                       | (single_evt ? error_id_i : '0);
        status_fatal_d = (status_fatal_q & ~(wr_status & reg_req_i.wdata[TMR_STATUS_FATAL_BIT]))
                       | uncorr_evt;
        threshold_d    = wr_thresh ? reg_req_i.wdata[CNT_W-1:0] : threshold_q;
        ctrl_d         = wr_ctrl ? reg_req_i.wdata[1:0] : ctrl_q;
        irq_d          = ctrl_q[TMR_CTRL_IRQ_EN_BIT] & (status_fatal_q | (|status_hart_q));
    end

    // Status, configuration and interrupt registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_hart_q  <= '0;
            status_fatal_q <= 1'b0;
            threshold_q    <= CNT_W'(THRESH_RST);
            ctrl_q         <= 2'b11;
            irq_q          <= 1'b0;
        end else begin
            status_hart_q  <= status_hart_d;
            status_fatal_q <= status_fatal_d;
            threshold_q    <= threshold_d;
            ctrl_q         <= ctrl_d;
            irq_q          <= irq_d;
        end
    end

    // Lowest-numbered hart at or above threshold, from the registered counters
    always_comb begin
        sel_hart = '0;
        for (int k = int'(NHARTS) - 1; k >= 0; k--) begin
            if (cnt[k] >= threshold_q) begin
                sel_hart    = '0;
                sel_hart[k] = 1'b1;
            end
        end
    end

    // Recovery FSM next state; uncorrectable events take priority over ack and new requests
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        hart_d  = hart_q;
        fatal_d = fatal_q;
        ack_clr = '0;
        case (state_q)
            TMR_IDLE: begin
                if (uncorr_evt) begin
                    state_d = TMR_FATAL;
                    fatal_d = 1'b1;
                end else if (ctrl_q[TMR_CTRL_REC_EN_BIT] && (threshold_q != '0) && (sel_hart != '0)) begin
                    state_d = TMR_REQ;
                    req_d   = 1'b1;
                    hart_d  = sel_hart;
                end
            end
            TMR_REQ: begin
                if (uncorr_evt) begin
                    state_d = TMR_FATAL;
                    req_d   = 1'b0;
                    hart_d  = '0;
                    fatal_d = 1'b1;
                end else if (recovery_ack_i) begin
                    state_d = TMR_IDLE;
                    req_d   = 1'b0;
                    hart_d  = '0;
                    ack_clr = hart_q;
                end
            end
            TMR_FATAL: begin
                if (wr_status && reg_req_i.wdata[TMR_STATUS_FATAL_BIT] && !uncorr_evt) begin
                    state_d = TMR_IDLE;
                    fatal_d = 1'b0;
                end
            end
            default: begin
                state_d = TMR_IDLE;
                req_d   = 1'b0;
                hart_d  = '0;
                fatal_d = 1'b0;
            end
        endcase
    end

    // Recovery FSM state and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TMR_IDLE;
            req_q   <= 1'b0;
            hart_q  <= '0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            hart_q  <= hart_d;
            fatal_q <= fatal_d;
        end
    end

`ifdef CEI_TMR_ERR_TIMESTAMP_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] ts_q, ts_d;

    // Free-running cycle count; stamp the first event after status was empty, drop it when status empties
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        ts_d    = ts_q;
        if (evt && !(status_fatal_q | (|status_hart_q))) begin
            ts_d = cycle_q;
        end else if ((status_fatal_q | (|status_hart_q)) && !(status_fatal_d | (|status_hart_d))) begin
            ts_d = '0;
        end
    end

    // Timestamp registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q <= '0;
            ts_q    <= '0;
        end else begin
            cycle_q <= cycle_d;
            ts_q    <= ts_d;
        end
    end
`endif

    // Combinational CSR read mux; unmapped offsets read as zero
    always_comb begin
        rdata = '0;
        if (reg_req_i.addr == TMR_STATUS_OFFSET) begin
            rdata = {status_fatal_q, {(31 - NHARTS){1'b0}}, status_hart_q};
        end else if (reg_req_i.addr == TMR_THRESHOLD_OFFSET) begin
            rdata = 32'(threshold_q);
        end else if (reg_req_i.addr == TMR_CTRL_OFFSET) begin
            rdata = 32'(ctrl_q);
`ifdef CEI_TMR_ERR_TIMESTAMP_EN
        end else if (reg_req_i.addr == TMR_TIMESTAMP_OFFSET) begin
            rdata = ts_q;
`endif
        end
        for (int k = 0; k < int'(NHARTS); k++) begin
            if (reg_req_i.addr == TMR_CNT_OFFSET + 32'(4 * k)) begin
                rdata = 32'(cnt[k]);
            end
        end
    end

    assign reg_rsp_o.rdata = rdata;
    assign reg_rsp_o.ready = 1'b1;
    assign reg_rsp_o.error = 1'b0;

    assign recovery_req_o  = req_q;
    assign recovery_hart_o = hart_q;
    assign fatal_o         = fatal_q;
    assign irq_o           = irq_q;

endmodule
